dmem_lsu: RTL

- Load/store initiator that drives the word-wide data memory port (A, WD, WE, RD) on behalf of the pipeline's MEM stage.
- Accepts RV32I load/store requests: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Loads perform lane extraction and sign/zero extension. SB and SH are performed as read-modify-write, because the memory has only a word write enable.
- Sits between the core's MEM stage and the data memory; it is the only master of that memory port.

---
 rtl/dmem_lsu_pkg.sv | 54 +++++
 rtl/dmem_lsu_align.sv | 52 +++++
 rtl/dmem_lsu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: FSM state
// encoding, RV32I funct3 codes, the registered request payload and the
// request-legality helpers.
package dmem_lsu_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned XLEN    = 32;

   localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] S_ACCESS = 2'd1;
   localparam logic [STATE_W-1:0] S_MERGE  = 2'd2;
   localparam logic [STATE_W-1:0] S_DONE   = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Request fields held for the duration of one operation
   typedef struct packed {
      logic            we;
      logic [2:0]      funct3;
      logic [1:0]      lane;
      logic [XLEN-1:0] wdata;
   } lsu_op_t;

   // Natural alignment for the access width encoded in funct3[1:0]
   function automatic logic is_aligned(input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
      logic ok;
      case (funct3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~addr_lo[0];
         2'b10:   ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Loads allow B/H/W/BU/HU; stores only B/H/W
   function automatic logic legal_funct3(input logic       we,
                                         input logic [2:0] funct3);
      logic ok;
      if (we) begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end else begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational lane steering for the load/store unit.
//   word        : word read from memory
//   funct3      : RV32I width/sign code
//   lane        : byte address bits [1:0]
//   wdata       : store data (low byte/halfword used for SB/SH)
//   load_data_c : selected lane, sign- or zero-extended
//   merged_c    : word with the store lane replaced by wdata
module lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   output logic [31:0] load_data_c,
   output logic [31:0] merged_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane extraction
   always_comb begin
      byte_sel = word[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   // Load extension
   always_comb begin
      case (funct3)
         F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_c = {24'h0, byte_sel};
         F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_c = {16'h0, half_sel};
         default: load_data_c = word;
      endcase
   end

   // Store merge into the old word
   always_comb begin
      merged_c = word;
      case (funct3)
         F3_B:    merged_c[{lane, 3'b000} +: 8] = wdata[7:0];
         F3_H: begin
            if (lane[1]) merged_c[31:16] = wdata[15:0];
            else         merged_c[15:0]  = wdata[15:0];
         end
         default: merged_c = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator and sole master of the word-wide data memory port.
// Loads are lane-extracted and extended; SB/SH are done as read-modify-write.
//   CLK, RST              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_we/funct3/addr/wdata : request payload
//   resp_valid/rdata/err  : one-cycle completion pulse with result
//   mem_a/mem_wd/mem_we   : memory address (byte offset), write data, enable
//   mem_rd                : combinational read data for mem_a
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
   parameter int unsigned DMEM_SIZE = 32768
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [31:0] MEM_BYTES = 32'(DMEM_SIZE * 4);

   logic [STATE_W-1:0] state, state_n;
   lsu_op_t            op, op_n;
   logic               req_ready_n, resp_valid_n, resp_err_n, mem_we_n;
   logic [31:0]        resp_rdata_n, mem_a_n, mem_wd_n;

   logic [31:0]        req_off_c;
   logic               req_ok_c;
   logic [31:0]        load_data_c, merged_c;

   // Request decode; addresses below the base wrap and fail the range test
   assign req_off_c = req_addr - DMEM_BASE;
   assign req_ok_c  = legal_funct3(req_we, req_funct3) &&
                      (req_off_c < MEM_BYTES) &&
                      is_aligned(req_funct3, req_addr[1:0]);

   lsu_align u_align (
      .word        (mem_rd),
      .funct3      (op.funct3),
      .lane        (op.lane),
      .wdata       (op.wdata),
      .load_data_c (load_data_c),
      .merged_c    (merged_c)
   );

   // Next state and next registered outputs
   always_comb begin
      state_n      = state;
      op_n         = op;
      req_ready_n  = 1'b0;
      resp_valid_n = 1'b0;
      resp_err_n   = 1'b0;
      resp_rdata_n = 32'h0;
      mem_a_n      = mem_a;
      mem_wd_n     = mem_wd;
      mem_we_n     = 1'b0;

      case (state)
         S_IDLE: begin
            req_ready_n = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_n = 1'b0;
               op_n.we     = req_we;
               op_n.funct3 = req_funct3;
               op_n.lane   = req_addr[1:0];
               op_n.wdata  = req_wdata;
               if (!req_ok_c) begin
                  state_n      = S_DONE;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
               end else begin
                  state_n = S_ACCESS;
                  mem_a_n = req_off_c & ~32'h3;
                  // Full-word store writes during ACCESS directly
                  if (req_we && (req_funct3 == F3_W)) begin
                     mem_we_n = 1'b1;
                     mem_wd_n = req_wdata;
                  end
               end
            end
         end

         S_ACCESS: begin
            if (!op.we) begin
               state_n      = S_DONE;
               resp_valid_n = 1'b1;
               resp_rdata_n = load_data_c;
            end else if (op.funct3 == F3_W) begin
               state_n      = S_DONE;
               resp_valid_n = 1'b1;
            end else begin
               // mem_wd doubles as the merge buffer for the write in MERGE
               state_n  = S_MERGE;
               mem_we_n = 1'b1;
               mem_wd_n = merged_c;
            end
         end

         S_MERGE: begin
            state_n      = S_DONE;
            resp_valid_n = 1'b1;
         end

         S_DONE: begin
            state_n     = S_IDLE;
            req_ready_n = 1'b1;
         end

         default: begin
            state_n     = S_IDLE;
            req_ready_n = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         op         <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         mem_a      <= 32'h0;
         mem_wd     <= 32'h0;
         mem_we     <= 1'b0;
      end else begin
         state      <= state_n;
         op         <= op_n;
         req_ready  <= req_ready_n;
         resp_valid <= resp_valid_n;
         resp_err   <= resp_err_n;
         resp_rdata <= resp_rdata_n;
         mem_a      <= mem_a_n;
         mem_wd     <= mem_wd_n;
         mem_we     <= mem_we_n;
      end
   end

endmodule
